cla_wide_seq: RTL
=================

// Module: cla_wide_seq
// PURPOSE
//  Multi-cycle sequencer that adds or subtracts WORDS*BITWIDTH-bit operands on one BITWIDTH-bit cla instance.
//  Processes one word per cycle, LSW first, and registers the word carry between cycles.
//  Gives wide add/sub without a wide carry chain; sits between a requester (valid/ready) and a consumer.
// PARAMETERS
//  BITWIDTH  8  width of the internal cla slice (bits per word)
//  WORDS     4  number of slices per operation (>=1); total width W = BITWIDTH*WORDS
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  start_valid  in   1  request valid; op_a/op_b/op_sub/carry_in are sampled on acceptance
//  start_ready  out  1  high only in IDLE and when rst is low
//  op_a         in   W  operand A
//  op_b         in   W  operand B
//  op_sub       in   1  1: A - B (A + ~B + 1, carry_in ignored); 0: A + B + carry_in
//  carry_in     in   1  initial carry for add
//  busy         out  1  high in RUN and DONE
//  res_valid    out  1  result valid; held until res_ready
//  res_ready    in   1  consumer accepts result
//  result       out  W  sum/difference, registered
//  carry_out    out  1  carry out of MSW (sub: 1 = no borrow)
//  overflow     out  1  two's-complement overflow of the W-bit op
// BEHAVIOUR
//  Reset: state=IDLE, word index=0, result=0, carry_out=0, overflow=0, res_valid=0, busy=0.
//   start_ready=0 while rst=1.
//  FSM states are IDLE, RUN, DONE.
//   IDLE: on start_valid&&start_ready, capture op_a and b_eff into registers.
//    b_eff = op_sub ? ~op_b : op_b.
//    Carry reg <= op_sub ? 1 : carry_in. Index <= 0. State -> RUN.
//   RUN: cla inputs are a_reg[idx], b_reg[idx] and the carry reg.
//    On each edge: result[idx] <= sum, carry reg <= cla carry_out, idx++.
//    On the edge processing idx==WORDS-1: also set carry_out and overflow, then state -> DONE.
//   DONE: res_valid=1. result, carry_out and overflow are stable.
//    On res_valid&&res_ready -> IDLE. start_ready is 0 in this cycle, so there is no same-cycle restart.
//  Latency: res_valid rises exactly WORDS edges after the acceptance edge. Throughput is 1 op per WORDS+2 cycles minimum.
//  overflow = (a_reg MSB == b_eff MSB) && (result MSB != a_reg MSB). It is computed from the final word.
//  The cla block_propagate/block_generate outputs are unused.
//  All state updates are synchronous. Outputs are registered, except start_ready/busy/res_valid, which decode the state register.
//  Boundaries:
//   start_valid in RUN/DONE is ignored (not captured). The requester holds it until start_ready.
//   res_ready low indefinitely: stay in DONE with outputs frozen.
//   res_ready high outside DONE has no effect.
//   rst in any state (including mid-RUN) aborts the op. No res_valid is issued for it. Partial result is cleared to 0.
//   WORDS=1: single RUN cycle. res_valid 1 edge after acceptance.
//   idx wraps only via reset or IDLE re-entry. It never exceeds WORDS-1.
// TESTING (BITWIDTH=8, WORDS=4)
//  add 0xFFFFFFFF+0x00000001, cin=0 -> result=0x00000000, carry_out=1, overflow=0; res_valid exactly 4 edges after accept.
//  add 0x000000FF+0x00000000, cin=1 -> result=0x00000100, carry_out=0 (carry propagates across the word boundary).
//  add 0x7FFFFFFF+0x00000001 -> result=0x80000000, overflow=1, carry_out=0.
//   sub 0x00000005-0x00000007 -> 0xFFFFFFFE, carry_out=0, overflow=0.
//  Backpressure: res_ready=0 for 10 cycles, pulse start_valid with new operands -> result unchanged, start_ready=0, second op not captured.
//   Then res_ready=1 -> IDLE next edge.
//  rst=1 one cycle while idx=2 -> res_valid never rises for that op, result=0.
//   start_ready=1 the first cycle rst=0. A new op then completes correctly.

Source files
------------

// File: rtl/cla_wide_seq.sv
// Wide add/sub built from one narrow carry-lookahead slice.
// One word per cycle, LSW first, with the word carry held in a register.

module cla #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         block_propagate,
  output logic         block_generate
);

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a flat sum of products over g/p, so no ripple path.
  always_comb begin
    logic t;
    logic pp;
    t  = 1'b0;
    pp = 1'b0;
    c  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      pp = cin;
      for (int k = 0; k <= i; k++) begin
        pp = pp & p[k];
      end
      c[i+1] = pp;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int k = j + 1; k <= i; k++) begin
          t = t & p[k];
        end
        c[i+1] = c[i+1] | t;
      end
    end
  end

  always_comb begin
    logic t;
    t = 1'b0;
    block_generate = 1'b0;
    for (int j = 0; j < W; j++) begin
      t = g[j];
      for (int k = j + 1; k < W; k++) begin
        t = t & p[k];
      end
      block_generate = block_generate | t;
    end
  end

  assign block_propagate = &p;
  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];

endmodule

module cla_wide_seq #(
  parameter int BITWIDTH = 8,
  parameter int WORDS    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [BITWIDTH*WORDS-1:0] op_a,
  input  logic [BITWIDTH*WORDS-1:0] op_b,
  input  logic                      op_sub,
  input  logic                      carry_in,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [BITWIDTH*WORDS-1:0] result,
  output logic                      carry_out,
  output logic                      overflow
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [WORDS-1:0][BITWIDTH-1:0] a_reg;
  logic [WORDS-1:0][BITWIDTH-1:0] b_reg;
  logic [WORDS-1:0][BITWIDTH-1:0] res_w;
  logic [IW-1:0]                  idx;
  logic                           cy;

  logic [BITWIDTH-1:0] sum;
  logic                cout;
  logic                unused_bp;
  logic                unused_bg;

  logic a_msb;
  logic b_msb;

  cla #(
    .W (BITWIDTH)
  ) u_cla (
    .a               (a_reg[idx]),
    .b               (b_reg[idx]),
    .cin             (cy),
    .sum             (sum),
    .cout            (cout),
    .block_propagate (unused_bp),
    .block_generate  (unused_bg)
  );

  assign a_msb = a_reg[WORDS-1][BITWIDTH-1];
  assign b_msb = b_reg[WORDS-1][BITWIDTH-1];

  assign start_ready = (state == IDLE) && !rst;
  assign busy        = (state == RUN) || (state == DONE);
  assign res_valid   = (state == DONE);
  assign result      = res_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cy        <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_w     <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg <= op_a;
            b_reg <= op_sub ? ~op_b : op_b;
            cy    <= op_sub ? 1'b1 : carry_in;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res_w[idx] <= sum;
          cy         <= cout;
          if (idx == LAST) begin
            carry_out <= cout;
            // Sign rule on the final word: like-signed inputs, flipped result.
            overflow  <= (a_msb == b_msb) &&
                         (sum[BITWIDTH-1] != a_msb);
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
